// File: rtl/issue_scoreboard_pkg.sv
// scoreboard_pkg: unit codes, default latencies and writeback slot entry shared by the issue scoreboard.
package scoreboard_pkg;
   localparam int REG_W     = 5;
   localparam int LAT_ALU_D = 1;
   localparam int LAT_MEM_D = 2;
   localparam int LAT_MUL_D = 4;
   typedef enum logic [1:0] {UNIT_ALU, UNIT_MEM, UNIT_MUL, UNIT_RSV} unit_e;
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      unit_e            unit;
   } slot_t;
endpackage

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decode request / issue / writeback bundle between decode and the scoreboard.
interface issue_scoreboard_if;
   import scoreboard_pkg::*;
   logic             stall;
   logic             req_valid;
   unit_e            req_unit;
   logic [REG_W-1:0] req_dst;
   logic             req_dst_en;
   logic [REG_W-1:0] req_src_a;
   logic [REG_W-1:0] req_src_b;
   logic             req_src_a_en;
   logic             req_src_b_en;
   logic             issue;
   logic             hold;
   logic             wb_valid;
   logic [REG_W-1:0] wb_reg;
   unit_e            wb_unit;
   logic             mul_busy;
   modport master (
      output stall, req_valid, req_unit, req_dst, req_dst_en,
             req_src_a, req_src_b, req_src_a_en, req_src_b_en,
      input  issue, hold, wb_valid, wb_reg, wb_unit, mul_busy
   );
   modport slave (
      input  stall, req_valid, req_unit, req_dst, req_dst_en,
             req_src_a, req_src_b, req_src_a_en, req_src_b_en,
      output issue, hold, wb_valid, wb_reg, wb_unit, mul_busy
   );
endinterface

// File: rtl/issue_scoreboard_shift.sv
// sb_result_shift: writeback slot shift register; slot 1 is the current writeback,
// entries advance one slot per non-stalled cycle and occupancy can be queried by position.
module sb_result_shift
   import scoreboard_pkg::*;
#(
   parameter int DEPTH = LAT_MUL_D,
   parameter int PW    = $clog2(DEPTH + 2)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_adv,
   input  logic          i_ins,
   input  logic [PW-1:0] i_ins_pos,
   input  slot_t         i_ins_entry,
   input  logic [PW-1:0] i_qpos,
   output logic          o_qbusy,
   output slot_t         o_head
);
   slot_t [DEPTH:1] r_slot;
   slot_t [DEPTH:1] w_nxt;

   // Empty entries are all-zero so the head reports reg/unit 0 when idle.
   always_comb begin
      w_nxt = r_slot >> $bits(slot_t);
      if (i_ins) w_nxt[i_ins_pos] = i_ins_entry;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_slot <= '0;
      else if (i_adv) r_slot <= w_nxt;

   assign o_head  = r_slot[1];
   assign o_qbusy = (i_qpos != '0 && i_qpos <= PW'(DEPTH)) ? r_slot[i_qpos].valid : 1'b0;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode issue control with RAW/WAW tracking, MUL occupancy and write-port scheduling.
// Define SB_FORWARD_EN to let a source bypass from the register being written back this cycle.
module issue_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NREG    = 32,
   parameter int LAT_ALU = LAT_ALU_D,
   parameter int LAT_MEM = LAT_MEM_D,
   parameter int LAT_MUL = LAT_MUL_D
) (
   input logic               clk,
   input logic               rst_n,
   issue_scoreboard_if.slave sb
);
   localparam int PW = $clog2(LAT_MUL + 2);
   localparam int CW = $clog2(LAT_MUL + 1);

   logic [NREG-1:0] r_pend;
   logic [CW-1:0]   r_mul_cnt;
   logic [PW-1:0]   w_lat;
   logic [PW-1:0]   w_qpos;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;
   logic            w_adv, w_ins, w_slot_busy, w_wb_valid;
   logic            w_byp_a, w_byp_b, w_raw, w_waw, w_struct;
   slot_t           w_head;
   slot_t           w_entry;

   assign w_adv  = ~sb.stall;
   assign w_lat  = sb.req_unit == UNIT_ALU ? PW'(LAT_ALU) :
                   sb.req_unit == UNIT_MEM ? PW'(LAT_MEM) : PW'(LAT_MUL);
   // An entry now at L+1 would land in slot L together with ours.
   assign w_qpos = w_lat + 1'b1;
   assign w_wb_valid = w_head.valid & ~sb.stall;

`ifdef SB_FORWARD_EN
   assign w_byp_a = w_wb_valid && sb.req_src_a == w_head.dst;
   assign w_byp_b = w_wb_valid && sb.req_src_b == w_head.dst;
`else
   assign w_byp_a = 1'b0;
   assign w_byp_b = 1'b0;
`endif

   assign w_raw    = (sb.req_src_a_en && sb.req_src_a != '0 && r_pend[sb.req_src_a] && !w_byp_a) ||
                     (sb.req_src_b_en && sb.req_src_b != '0 && r_pend[sb.req_src_b] && !w_byp_b);
   assign w_waw    = sb.req_dst_en && sb.req_dst != '0 && r_pend[sb.req_dst];
   assign w_struct = (sb.req_unit == UNIT_MUL && r_mul_cnt != '0) || w_slot_busy;

   assign sb.issue    = sb.req_valid & ~sb.stall & ~w_raw & ~w_waw & ~w_struct & (sb.req_unit != UNIT_RSV);
   assign sb.hold     = sb.req_valid & ~sb.issue & ~sb.stall;
   assign sb.wb_valid = w_wb_valid;
   assign sb.wb_reg   = w_head.dst;
   assign sb.wb_unit  = w_head.unit;
   assign sb.mul_busy = r_mul_cnt != '0;

   // Writes to r0 are discarded, so they take no slot and set no pending bit.
   assign w_ins   = sb.issue & sb.req_dst_en & (sb.req_dst != '0);
   assign w_entry = '{valid: 1'b1, dst: sb.req_dst, unit: sb.req_unit};
   assign w_set   = w_ins ? NREG'(1) << sb.req_dst : '0;
   assign w_clr   = w_wb_valid ? NREG'(1) << w_head.dst : '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_pend <= '0;
      else if (w_adv) r_pend <= (r_pend & ~w_clr) | w_set;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_mul_cnt <= '0;
      else if (sb.issue && sb.req_unit == UNIT_MUL) r_mul_cnt <= CW'(LAT_MUL - 1);
      else if (w_adv && r_mul_cnt != '0) r_mul_cnt <= r_mul_cnt - 1'b1;

   sb_result_shift #(.DEPTH(LAT_MUL), .PW(PW)) u_shift (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_adv       (w_adv),
      .i_ins       (w_ins),
      .i_ins_pos   (w_lat),
      .i_ins_entry (w_entry),
      .i_qpos      (w_qpos),
      .o_qbusy     (w_slot_busy),
      .o_head      (w_head)
   );
endmodule
